// File: rtl/heap_sort_pkg.sv
// Shared constants and types for the heap-sort frame sequencer and its FIFO.
package heap_sort_pkg;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 6;
    localparam int CNT_W  = 3;

    // Capacity as a counter-width constant, so comparisons stay width-matched.
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    // Sorter command opcodes carried in the top two bits of cmd_o.
    typedef enum logic [1:0] {
        OP_NOP  = 2'b00,
        OP_PUSH = 2'b01,
        OP_POP  = 2'b10
    } op_t;

    // Sequencer states: LOAD streams keys in, DRAIN pops them back out.
    typedef enum logic {
        ST_LOAD  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    // One sorter command word.
    typedef struct packed {
        op_t               op;
        logic [DATA_W-1:0] data;
    } cmd_t;

    // One output FIFO entry: sorted key plus end-of-frame tag.
    typedef struct packed {
        logic              last;
        logic [DATA_W-1:0] data;
    } out_entry_t;

endpackage

// File: rtl/hs_out_fifo2.sv
// Two-entry synchronous FIFO holding sorted keys with their last tag.
// Simultaneous write and read are legal at any occupancy of 1 or 2.
module hs_out_fifo2
    import heap_sort_pkg::*;
#(
    parameter int W = DATA_W + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         wr_en,
    input  logic [W-1:0] wr_data,
    input  logic         rd_en,
    output logic [W-1:0] rd_data,
    output logic [1:0]   count,
    output logic         full,
    output logic         empty
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic         do_wr;
    logic         do_rd;

    assign full    = (count == 2'd2);
    assign empty   = (count == 2'd0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Storage array: data only, qualified by count.
    // NOTE: the data array is deliberately left out of reset; count alone says
    // which entries are meaningful, and an unreset array maps to plain RAM/flops.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_wr) begin
                wr_ptr <= ~wr_ptr;
            end
            if (do_rd) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/heap_sort_sequencer.sv
// Frame sequencer in front of the heap-sort core: pushes one frame of keys,
// then pops them back under credit control into a 2-entry output FIFO and
// presents them as an ascending valid/ready stream with a last flag.
module heap_sort_sequencer
    import heap_sort_pkg::*;
(
    input  logic              system1000,
    input  logic              system1000_rstn,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    input  logic [DATA_W-1:0] in_data_i,
    input  logic              in_last_i,
    output logic [DATA_W+1:0] cmd_o,
    input  logic              rsp_valid_i,
    input  logic [DATA_W-1:0] rsp_data_i,
    output logic              out_valid_o,
    input  logic              out_ready_i,
    output logic [DATA_W-1:0] out_data_o,
    output logic              out_last_o,
    output logic              drop_o
);

    state_t           state_q,     state_d;
    logic [CNT_W-1:0] count_q,     count_d;
    logic [CNT_W-1:0] pops_left_q, pops_left_d;
    logic [CNT_W-1:0] rsp_cnt_q,   rsp_cnt_d;
    cmd_t             cmd_q,       cmd_d;
    logic             drop_q,      drop_d;
    logic             inflight_q;

    logic             accept;
    logic             pop_out;
    logic             can_pop;
    logic [2:0]       occ;

    logic             fifo_wr;
    logic             fifo_rd;
    out_entry_t       fifo_wr_entry;
    out_entry_t       fifo_rd_entry;
    logic [1:0]       fifo_count;
    logic             fifo_full;
    logic             fifo_empty;

    // Input is only offered in LOAD and never while reset is asserted.
    assign in_ready_o = (state_q == ST_LOAD) && system1000_rstn;
    assign accept     = in_valid_i && in_ready_o;

    // A POP currently on cmd_o will produce a response one cycle from now.
    assign pop_out = (cmd_q.op == OP_POP);

    // Slots already promised in the FIFO: stored entries, the response arriving
    // now, the POP on the wire, minus the entry leaving this cycle. A new POP is
    // only issued while that total stays below the FIFO depth of 2.
    assign occ     = 3'(fifo_count) + 3'(inflight_q) + 3'(pop_out) - 3'(fifo_rd);
    assign can_pop = (pops_left_q != '0) && (occ < 3'd2);

    // Responses are accepted only when a POP was actually in flight.
    assign fifo_wr            = rsp_valid_i && inflight_q;
    assign fifo_wr_entry.data = rsp_data_i;
    assign fifo_wr_entry.last = ((rsp_cnt_q + CNT_W'(1)) == count_q);
    assign fifo_rd            = out_valid_o && out_ready_i;

    assign out_valid_o = !fifo_empty;
    assign out_data_o  = fifo_rd_entry.data;
    assign out_last_o  = fifo_rd_entry.last;
    assign cmd_o       = cmd_q;
    assign drop_o      = drop_q;

    hs_out_fifo2 #(
        .W (DATA_W + 1)
    ) u_out_fifo (
        .clk     (system1000),
        .rst_n   (system1000_rstn),
        .wr_en   (fifo_wr),
        .wr_data (fifo_wr_entry),
        .rd_en   (fifo_rd),
        .rd_data (fifo_rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // Next-state, counters and the command to register for the next cycle.
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pops_left_d = pops_left_q;
        rsp_cnt_d   = rsp_cnt_q + CNT_W'(fifo_wr);
        drop_d      = drop_q;
        cmd_d.op    = OP_NOP;
        cmd_d.data  = '0;

        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (count_q < DEPTH_C) begin
                        cmd_d.op   = OP_PUSH;
                        cmd_d.data = in_data_i;
                        count_d    = count_q + CNT_W'(1);
                    end else begin
                        drop_d = 1'b1;
                    end
                    if (in_last_i) begin
                        state_d     = ST_DRAIN;
                        pops_left_d = count_d;
                    end
                end
            end
            ST_DRAIN: begin
                if (can_pop) begin
                    cmd_d.op    = OP_POP;
                    pops_left_d = pops_left_q - CNT_W'(1);
                end
                // The final key leaving means the sorter is empty again.
                if (fifo_rd && out_last_o) begin
                    state_d     = ST_LOAD;
                    count_d     = '0;
                    pops_left_d = '0;
                    rsp_cnt_d   = '0;
                    drop_d      = 1'b0;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    // State, counters, command register and in-flight tracking.
    always_ff @(posedge system1000 or negedge system1000_rstn) begin
        if (!system1000_rstn) begin
            state_q     <= ST_LOAD;
            count_q     <= '0;
            pops_left_q <= '0;
            rsp_cnt_q   <= '0;
            drop_q      <= 1'b0;
            cmd_q       <= '0;
            inflight_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pops_left_q <= pops_left_d;
            rsp_cnt_q   <= rsp_cnt_d;
            drop_q      <= drop_d;
            cmd_q       <= cmd_d;
            inflight_q  <= pop_out;
        end
    end

endmodule
